// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset main control: Moore FSM driving datapath strobes,
// plus a retired-instruction counter and an unsupported-opcode flag.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             BEQorBNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t cur;
  ctrl_t  ctrl;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == MEM_WB) || (s == MEM_WRITE) || (s == R_WB) ||
           (s == BRANCH) || (s == JUMP) || (s == ADDI_WB);
  endfunction

  function automatic state_t next_of(input state_t s, input logic [5:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   n = MEM_ADDR;
          OP_R:           n = R_EXEC;
          OP_BEQ, OP_BNE: n = BRANCH;
          OP_J:           n = JUMP;
          OP_ADDI:        n = ADDI_EXEC;
          default:        n = FETCH;
        endcase
      end
      MEM_ADDR:  n = (op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  n = MEM_WB;
      R_EXEC:    n = R_WB;
      ADDI_EXEC: n = ADDI_WB;
      default:   n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEM_ADDR, ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ADDI_WB: c.reg_write = 1'b1;
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= FETCH;
      ctrl        <= ctrl_of(FETCH);
      instr_count <= '0;
    end else begin
      cur  <= next_of(cur, Op);
      ctrl <= ctrl_of(next_of(cur, Op));
      if (is_terminal(cur))
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state       = cur;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCSource    = ctrl.pc_source;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;

  // Branch polarity and the illegal flag follow Op live, since IR is valid only from DECODE.
  assign BEQorBNE   = (cur == BRANCH) && (Op == OP_BEQ);
  assign illegal_op = (cur == DECODE) && !is_supported(Op);

endmodule
